// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR stepping engine.
//   TAP_DEFAULTS  : the eight power-on tap patterns (8-bit source values)
//   lfsr_state_t  : control FSM encoding
//   tap_default() : default pattern for a table entry, zero-extended
//   lfsr_next()   : one LFSR step on a right-aligned state of up to LFSR_MAX_W bits
package lfsr_pkg;

  // Widest LFSR the shared step function can represent.
  localparam int unsigned LFSR_MAX_W    = 32;
  localparam int unsigned TAP_DEFAULT_N = 8;

  localparam logic [7:0] TAP_DEFAULTS [TAP_DEFAULT_N] = '{
    8'h60, 8'h48, 8'h78, 8'h72, 8'h6A, 8'h69, 8'h5C, 8'h7E
  };

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } lfsr_state_t;

  // Entries beyond the default list reset to zero; callers truncate or
  // keep the zero-extension by casting to their own width.
  function automatic logic [LFSR_MAX_W-1:0] tap_default(input int unsigned idx);
    logic [LFSR_MAX_W-1:0] r;
    r = '0;
    if (idx < TAP_DEFAULT_N) r = LFSR_MAX_W'(TAP_DEFAULTS[idx[2:0]]);
    return r;
  endfunction

  // Shift left, feed back the parity of the tapped bits, keep `width` bits.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
    input logic [LFSR_MAX_W-1:0] state,
    input logic [LFSR_MAX_W-1:0] tap,
    input int unsigned           width
  );
    logic                  fb;
    logic [LFSR_MAX_W-1:0] mask;
    fb   = ^(state & tap);
    mask = (width >= LFSR_MAX_W) ? '1 : ((LFSR_MAX_W'(1) << width) - LFSR_MAX_W'(1));
    return ((state << 1) | LFSR_MAX_W'(fb)) & mask;
  endfunction

endpackage

// File: rtl/lfsr_tap_table.sv
// Writable tap-pattern table.
//   clk, rst         : clock, synchronous active-high reset (restores defaults)
//   wr_en/idx/data   : synchronous write port
//   rd_idx / rd_data : combinational read port (returns pre-write contents)
module lfsr_tap_table
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 7,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_idx] = wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= WIDTH'(tap_default(i));
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/lfsr_engine.sv
// Programmable LFSR stepping engine: tap table + burst/single-step LFSR.
//   Clk, Reset           : clock, synchronous active-high reset
//   TapWrEn/Idx/Data     : tap table write port
//   Start/StartIdx/Seed/Count : load seed, latch tap entry, run Count steps
//   Advance              : single step while idle
//   Busy, Done           : burst in progress / one-cycle completion pulse
//   State, Tap, Zero     : LFSR register, latched tap, lock-up flag
// WIDTH must not exceed lfsr_pkg::LFSR_MAX_W.
module lfsr_engine
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 7,
  parameter int DEPTH = 8,
  parameter int CNTW  = 8
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     TapWrEn,
  input  logic [$clog2(DEPTH)-1:0] TapWrIdx,
  input  logic [WIDTH-1:0]         TapWrData,
  input  logic                     Start,
  input  logic [$clog2(DEPTH)-1:0] StartIdx,
  input  logic [WIDTH-1:0]         Seed,
  input  logic [CNTW-1:0]          Count,
  input  logic                     Advance,
  output logic                     Busy,
  output logic                     Done,
  output logic [WIDTH-1:0]         State,
  output logic [WIDTH-1:0]         Tap,
  output logic                     Zero
);

  lfsr_state_t      fsm_q,  fsm_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] tap_q,  tap_d;
  logic [CNTW-1:0]  cnt_q,  cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] rd_tap;
  logic [WIDTH-1:0] lfsr_step;

  lfsr_tap_table #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_table (
    .clk     (Clk),
    .rst     (Reset),
    .wr_en   (TapWrEn),
    .wr_idx  (TapWrIdx),
    .wr_data (TapWrData),
    .rd_idx  (StartIdx),
    .rd_data (rd_tap)
  );

  assign lfsr_step = WIDTH'(lfsr_next(LFSR_MAX_W'(lfsr_q), LFSR_MAX_W'(tap_q), WIDTH));

  always_comb begin
    fsm_d  = fsm_q;
    lfsr_d = lfsr_q;
    tap_d  = tap_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    unique case (fsm_q)
      IDLE: begin
        // Start outranks Advance; rd_tap is the table before any same-cycle write.
        if (Start) begin
          tap_d  = rd_tap;
          lfsr_d = Seed;
          cnt_d  = Count;
          if (Count != '0) fsm_d  = RUN;
          else             done_d = 1'b1;
        end else if (Advance) begin
          lfsr_d = lfsr_step;
        end
      end
      RUN: begin
        lfsr_d = lfsr_step;
        cnt_d  = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) begin
          fsm_d  = IDLE;
          done_d = 1'b1;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fsm_q  <= IDLE;
      lfsr_q <= '0;
      tap_q  <= WIDTH'(tap_default(0));
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      lfsr_q <= lfsr_d;
      tap_q  <= tap_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign Busy  = (fsm_q == RUN);
  assign Done  = done_q;
  assign State = lfsr_q;
  assign Tap   = tap_q;
  assign Zero  = (lfsr_q == '0);

endmodule

// File: tb/tb_lfsr_engine.sv
module tb_lfsr_engine;
  import lfsr_pkg::*;

  localparam int WIDTH = 7;
  localparam int DEPTH = 8;
  localparam int CNTW  = 8;

  logic             Clk = 1'b0;
  logic             Reset, TapWrEn, Start, Advance;
  logic [2:0]       TapWrIdx, StartIdx;
  logic [WIDTH-1:0] TapWrData, Seed;
  logic [CNTW-1:0]  Count;
  logic             Busy, Done, Zero;
  logic [WIDTH-1:0] State, Tap;

  int n_chk = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  lfsr_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .Clk(Clk), .Reset(Reset), .TapWrEn(TapWrEn), .TapWrIdx(TapWrIdx),
    .TapWrData(TapWrData), .Start(Start), .StartIdx(StartIdx), .Seed(Seed),
    .Count(Count), .Advance(Advance), .Busy(Busy), .Done(Done),
    .State(State), .Tap(Tap), .Zero(Zero)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: burst bookkeeping as "steps still owed".
  logic [WIDTH-1:0] m_table [DEPTH];
  logic [WIDTH-1:0] m_state, m_tap;
  int               m_owed;
  bit               m_done;
  bit               m_valid = 0;
  localparam logic [7:0] DEF [8] = '{8'h60, 8'h48, 8'h78, 8'h72, 8'h6A, 8'h69, 8'h5C, 8'h7E};

  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] t);
    return WIDTH'(lfsr_next(32'(s), 32'(t), WIDTH));
  endfunction

  always @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) m_table[i] = WIDTH'(DEF[i]);
      m_state = '0;
      m_tap   = WIDTH'(DEF[0]);
      m_owed  = 0;
      m_done  = 0;
      m_valid = 1;
    end else if (m_valid) begin
      m_done = 0;
      if (m_owed > 0) begin
        m_state = step(m_state, m_tap);
        m_owed  = m_owed - 1;
        m_done  = (m_owed == 0);
      end else if (Start) begin
        m_tap   = m_table[StartIdx];
        m_state = Seed;
        m_owed  = int'(Count);
        m_done  = (Count == 0);
      end else if (Advance) begin
        m_state = step(m_state, m_tap);
      end
      if (TapWrEn) m_table[TapWrIdx] = TapWrData;
    end
  end

  always @(negedge Clk) begin
    if (m_valid) begin
      chk("model_state", 32'(State), 32'(m_state));
      chk("model_tap",   32'(Tap),   32'(m_tap));
      chk("model_busy",  32'(Busy),  32'(m_owed > 0));
      chk("model_done",  32'(Done),  32'(m_done));
      chk("model_zero",  32'(Zero),  32'(m_state == '0));
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    Reset = 0; TapWrEn = 0; Start = 0; Advance = 0;
    TapWrIdx = '0; TapWrData = '0; StartIdx = '0; Seed = '0; Count = '0;
  endtask

  task automatic do_reset();
    Reset = 1; tick(); tick(); Reset = 0;
  endtask

  task automatic start(input logic [2:0] idx, input logic [WIDTH-1:0] sd, input logic [CNTW-1:0] cnt);
    Start = 1; StartIdx = idx; Seed = sd; Count = cnt;
    tick();
    Start = 0;
  endtask

  logic [7:0] burst_exp [7] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h41, 8'h03};

  initial begin
    idle_inputs();
    do_reset();
    // Reset defaults
    chk("rst_state", 32'(State), 32'h00);
    chk("rst_zero",  32'(Zero),  32'h1);
    chk("rst_busy",  32'(Busy),  32'h0);
    chk("rst_done",  32'(Done),  32'h0);
    chk("rst_tap",   32'(Tap),   32'h60);
    for (int i = 0; i < 8; i++) begin
      start(3'(i), 7'h01, 8'd0);
      chk("table_default", 32'(Tap), 32'(DEF[i]));
    end

    // Burst from seed 0x01, tap 0x60, 7 steps
    start(3'd0, 7'h01, 8'd7);
    chk("burst_e0_state", 32'(State), 32'h01);
    chk("burst_e0_busy",  32'(Busy),  32'h1);
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("burst_state", 32'(State), 32'(burst_exp[k]));
      chk("burst_busy",  32'(Busy),  (k == 6) ? 32'h0 : 32'h1);
      chk("burst_done",  32'(Done),  (k == 6) ? 32'h1 : 32'h0);
    end
    tick();
    chk("burst_done_one_cycle", 32'(Done), 32'h0);

    // Count = 0
    start(3'd0, 7'h55, 8'd0);
    chk("cnt0_state", 32'(State), 32'h55);
    chk("cnt0_done",  32'(Done),  32'h1);
    chk("cnt0_busy",  32'(Busy),  32'h0);
    tick();
    chk("cnt0_done_clear", 32'(Done), 32'h0);

    // Interference during RUN
    start(3'd0, 7'h01, 8'd10);
    tick();
    TapWrEn = 1; TapWrIdx = 3'd0; TapWrData = 7'h7F;
    Start = 1; StartIdx = 3'd3; Seed = 7'h11; Count = 8'd3; Advance = 1;
    tick();
    idle_inputs();
    for (int k = 3; k <= 10; k++) begin
      tick();
      if (k < 10) chk("intf_busy", 32'(Busy), 32'h1);
    end
    chk("intf_state", 32'(State), 32'h18);
    chk("intf_tap",   32'(Tap),   32'h60);
    chk("intf_done",  32'(Done),  32'h1);
    start(3'd0, 7'h01, 8'd0);
    chk("intf_newtap", 32'(Tap), 32'h7F);

    // Single steps and Start+Advance
    do_reset();
    start(3'd0, 7'h20, 8'd0);
    Advance = 1;
    tick();
    chk("adv1", 32'(State), 32'h41);
    tick();
    chk("adv2", 32'(State), 32'h03);
    Start = 1; StartIdx = 3'd0; Seed = 7'h33; Count = 8'd0;
    tick();
    idle_inputs();
    chk("start_adv", 32'(State), 32'h33);

    // Same-cycle Start and write to the same entry
    TapWrEn = 1; TapWrIdx = 3'd2; TapWrData = 7'h11;
    start(3'd2, 7'h01, 8'd0);
    TapWrEn = 0;
    chk("rd_before_wr", 32'(Tap), 32'h78);
    start(3'd2, 7'h01, 8'd0);
    chk("rd_after_wr", 32'(Tap), 32'h11);

    // All-zero seed
    start(3'd1, 7'h00, 8'd3);
    tick(); tick(); tick();
    chk("zero_state", 32'(State), 32'h00);
    chk("zero_flag",  32'(Zero),  32'h1);

    // Reset mid-burst, with entry 0 modified beforehand
    TapWrEn = 1; TapWrIdx = 3'd0; TapWrData = 7'h7F;
    tick();
    TapWrEn = 0;
    start(3'd0, 7'h05, 8'd20);
    tick(); tick();
    Reset = 1; tick(); Reset = 0;
    chk("rstmid_busy",  32'(Busy),  32'h0);
    chk("rstmid_state", 32'(State), 32'h00);
    chk("rstmid_done",  32'(Done),  32'h0);
    tick();
    chk("rstmid_done2", 32'(Done),  32'h0);
    start(3'd0, 7'h01, 8'd0);
    chk("rstmid_table", 32'(Tap), 32'h60);

    // Randomized traffic checked by the model every cycle
    for (int c = 0; c < 600; c++) begin
      Reset     = ($urandom_range(0, 199) == 0);
      TapWrEn   = ($urandom_range(0, 5) == 0);
      TapWrIdx  = 3'($urandom_range(0, 7));
      TapWrData = 7'($urandom);
      Start     = ($urandom_range(0, 7) == 0);
      StartIdx  = 3'($urandom_range(0, 7));
      Seed      = 7'($urandom);
      Count     = 8'($urandom_range(0, 12));
      Advance   = ($urandom_range(0, 2) == 0);
      tick();
    end
    idle_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/lfsr_engine.md
# lfsr_engine

Programmable LFSR stepping engine for the encryption/decryption datapath. It combines a writable, parametrised tap table with a burst-stepping LFSR register. This replaces the fixed 8-entry, 7-bit combinational tap lookup. Software selects a tap entry and a seed, then requests a burst of steps or single steps. The core reads `State` for keystream bytes.

## Interface
Parameters:
- `WIDTH`, 7: LFSR and tap width in bits (≥ 2).
- `DEPTH`, 8: number of tap-table entries (power of 2).
- `CNTW`, 8: width of the step-count input.

Ports (the reset is synchronous and active-high):
- `Clk` input, 1 bit: single clock; all state changes on the rising edge.
- `Reset` input, 1 bit: synchronous, active-high.
- `TapWrEn` input, 1 bit: write the tap table this cycle.
- `TapWrIdx` input, $clog2(DEPTH) bits: entry to write.
- `TapWrData` input, WIDTH bits: new tap pattern.
- `Start` input, 1 bit: load the seed and begin a burst.
- `StartIdx` input, $clog2(DEPTH) bits: tap entry used by the burst.
- `Seed` input, WIDTH bits: initial LFSR state.
- `Count` input, CNTW bits: number of steps in the burst.
- `Advance` input, 1 bit: single step while idle.
- `Busy` output, 1 bit: a burst is in progress.
- `Done` output, 1 bit: one-cycle pulse when a burst completes.
- `State` output, WIDTH bits: current LFSR state.
- `Tap` output, WIDTH bits: latched tap pattern in use.
- `Zero` output, 1 bit: `State` is all-zero (lock-up).

## Operation
- **Step function:** `next = {State[WIDTH-2:0], ^(State & Tap)}`. The register shifts left, and the feedback bit is the XOR reduction of the tapped bits.
- **Tap table reset:** on `Reset`, entries 0–7 load 0x60, 0x48, 0x78, 0x72, 0x6A, 0x69, 0x5C, 0x7E. These values are truncated or zero-extended to WIDTH. Entries ≥ 8 reset to 0.
- **Tap table writes:** take effect at the clock edge. A write has no effect on `Tap` until the next `Start`.
- **States:**
  - IDLE: `Busy` = 0.
    - On `Start`, the engine latches `Tap` = table[`StartIdx`] and `State` = `Seed`. It then goes to RUN if `Count` ≠ 0. If `Count` = 0 it stays in IDLE and pulses `Done` in the next cycle.
    - Otherwise, if `Advance` = 1, the engine performs one step with the latched `Tap`.
  - RUN: `Busy` = 1. Each cycle performs one step and decrements the remaining count. When the remaining count reaches 0 the engine returns to IDLE and pulses `Done`.
- **Priorities and boundaries:**
  - `Start` together with `Advance` in IDLE: `Start` wins.
  - `Start` or `Advance` while in RUN: ignored, with no effect on the burst.
  - `TapWrEn` to the entry currently in use during RUN: the table is updated, but the burst keeps using the latched `Tap`.
  - `Start` with `StartIdx` equal to `TapWrIdx` in the same cycle: `Tap` latches the old table value, because the table read happens before the write.
  - All-zero seed: stepping proceeds normally, `State` stays 0, and `Zero` = 1 throughout. There is no error and no auto-reseed.
- **Reset mid-burst:** the burst aborts. The engine returns to IDLE with `Busy`, `Done` = 0, and the table returns to its defaults.
- **Reset values:** `State` = 0, `Tap` = 0x60 (table[0]), `Busy` = 0, `Done` = 0, `Zero` = 1. The remaining-count register is 0.

## Timing
- `Start` sampled at edge E0 makes `State` = `Seed` and `Busy` = 1 from E0, when `Count` > 0.
- Steps occur at edges E1 through E`Count`.
- `Busy` falls and `Done` rises at E`Count`, and `Done` is held for exactly one cycle.
- With `Count` = 0: `Done` rises at E0 and `Busy` never asserts.
- The earliest next `Start` is accepted in the cycle in which `Done` is high, making bursts back-to-back.
- `Advance` has single-cycle latency: `State` updates at the sampling edge.
- `Zero` is combinational from `State`.
- Throughput is one step per cycle. A burst has a latency of `Count` + 1 edges from `Start` to `Done`.

## Structure
- **Package `lfsr_pkg`:**
  - `TAP_DEFAULTS` constant array holding the 8 default patterns.
  - Enum `lfsr_state_t` {IDLE, RUN}.
  - Function `lfsr_next(state, tap)` implementing the step function, shared with the testbench model.
- **Sub-module `lfsr_tap_table`:** registered DEPTH×WIDTH table with one synchronous write port and one combinational read port. It resets to `TAP_DEFAULTS`.
- **Top level:** the FSM, the latched `Tap`, the `State` register and the down-counter.

## Test plan
- **Reset defaults:** assert `Reset`, then release.
  - Required: `State` = 0, `Zero` = 1, `Busy` = 0, and the table reads back 0x60…0x7E.
- **Burst from seed 0x01:** `Start`, `StartIdx` = 0 (tap 0x60), `Seed` = 0x01, `Count` = 7.
  - Required states: 0x02, 0x04, 0x08, 0x10, 0x20, 0x41, 0x03.
  - `Done` pulses at E7; `Busy` is high for E0–E6.
- **Count = 0:** `Start` with `Seed` = 0x55.
  - Required: `State` = 0x55, `Done` pulses the next cycle, `Busy` never asserts.
- **Interference during RUN:** during a `Count` = 10 burst, write entry 0 with 0x7F and pulse `Start` and `Advance`.
  - Required: the burst is unaffected, still uses tap 0x60 and finishes at E10.
  - A following `Start` with idx 0 latches `Tap` = 0x7F.
- **Single steps:** `Advance` ×2 from `State` 0x20 with tap 0x60.
  - Required: 0x41, then 0x03.
  - `Start` together with `Advance`: the seed loads and no step is taken.
- **Reset mid-burst:** `Reset` at E3 of a `Count` = 20 burst.
  - Required: IDLE, `State` = 0, no `Done` pulse, and the table back to defaults.
